// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2)[x] multiplier: consumes one D-bit digit of b per clock
// (MSB digit first), with an optional single-cycle fold modulo f(x).
module gf2m_digit_serial_mult #(
   parameter int M = 283,
   parameter int D = 16,
   parameter logic [M-1:0] POLY = M'(13'h10A1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [M-1:0]   a,
   input  logic [M-1:0]   b,
   input  logic           reduce,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*M-2:0] y,
   output logic           busy,
   output logic [1:0]     dbg_state
);

   localparam int W  = 2 * M - 1;
   localparam int N  = (M + D - 1) / D;
   localparam int ND = N * D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_RED  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [M-1:0]   a_q, a_d;
   logic [ND-1:0]  b_q, b_d;
   logic           red_q, red_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   y_q, y_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           busy_q, busy_d;

   logic [D-1:0]   digit;
   logic [W-1:0]   pp;
   logic [W-1:0]   acc_next;
   logic [M-1:0]   rem;

   // Polynomial remainder of v modulo x^M + POLY, clearing one high bit per step.
   function automatic logic [M-1:0] fold(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [W-1:0] f;
      r = v;
      f = W'(POLY) | (W'(1) << M);
      for (int i = W - 1; i >= M; i--) begin
         if (r[i]) r = r ^ (f << (i - M));
      end
      return r[M-1:0];
   endfunction

   assign digit = b_q[ND-1 -: D];

   always_comb begin
      pp = '0;
      for (int j = 0; j < D; j++) begin
         if (digit[j]) pp = pp ^ (W'(a_q) << j);
      end
   end

   // Bits pushed past W-1 by the shift are always zero for a padded b.
   assign acc_next = (acc_q << D) ^ pp;
   assign rem      = fold(acc_q);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and ready is a registered output.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      red_d   = red_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = a;
               b_d     = ND'(b);
               red_d   = reduce;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            acc_d = acc_next;
            b_d   = b_q << D;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (red_q) begin
                  state_d = S_RED;
               end else begin
                  y_d     = acc_next;
                  state_d = S_DONE;
               end
            end
         end
         S_RED: begin
            y_d     = W'(rem);
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         red_q       <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         y_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         red_q       <= red_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         y_q         <= y_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign y         = y_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Bench for gf2m_digit_serial_mult: three instances (M=283/D=16, M=283/D=20,
// M=4/D=2) checked against a bit-serial carry-less multiply / long-division model.
module tb_gf2m_digit_serial_mult;

   localparam int M = 283;
   localparam int W = 2 * M - 1;
   localparam logic [M-1:0] POLY_BIG   = M'(13'h10A1);
   localparam logic [M-1:0] POLY_SMALL = M'(4'b0011);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]   sel;
   logic         in_valid;
   logic [M-1:0] a_in, b_in;
   logic         reduce_in;
   logic         out_ready;

   logic iv16, iv20, iv4;
   assign iv16 = in_valid && (sel == 2'd0);
   assign iv20 = in_valid && (sel == 2'd1);
   assign iv4  = in_valid && (sel == 2'd2);

   logic         ir16, ov16, bz16;
   logic [W-1:0] y16;
   logic [1:0]   st16;
   logic         ir20, ov20, bz20;
   logic [W-1:0] y20;
   logic [1:0]   st20;
   logic         ir4, ov4, bz4;
   logic [6:0]   y4;
   logic [1:0]   st4;

   gf2m_digit_serial_mult #(.M(283), .D(16), .POLY(POLY_BIG)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a_in), .b(b_in),
      .reduce(reduce_in), .out_valid(ov16), .out_ready(out_ready), .y(y16), .busy(bz16),
      .dbg_state(st16));

   gf2m_digit_serial_mult #(.M(283), .D(20), .POLY(POLY_BIG)) u20 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv20), .in_ready(ir20), .a(a_in), .b(b_in),
      .reduce(reduce_in), .out_valid(ov20), .out_ready(out_ready), .y(y20), .busy(bz20),
      .dbg_state(st20));

   gf2m_digit_serial_mult #(.M(4), .D(2), .POLY(4'b0011)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a_in[3:0]), .b(b_in[3:0]),
      .reduce(reduce_in), .out_valid(ov4), .out_ready(out_ready), .y(y4), .busy(bz4),
      .dbg_state(st4));

   logic         cur_in_ready, cur_out_valid, cur_busy;
   logic [W-1:0] cur_y;
   logic [1:0]   cur_state;

   always_comb begin
      cur_in_ready  = ir16;
      cur_out_valid = ov16;
      cur_busy      = bz16;
      cur_y         = y16;
      cur_state     = st16;
      case (sel)
         2'd1: begin
            cur_in_ready = ir20; cur_out_valid = ov20; cur_busy = bz20;
            cur_y = y20; cur_state = st20;
         end
         2'd2: begin
            cur_in_ready = ir4; cur_out_valid = ov4; cur_busy = bz4;
            cur_y = '0; cur_y[6:0] = y4; cur_state = st4;
         end
         default: ;
      endcase
   end

   int checks = 0;
   int errors = 0;

   function automatic logic [M-1:0] rand_vec();
      logic [M-1:0] v;
      v = '0;
      for (int k = 0; k < 9; k++) v = (v << 32) | M'($urandom());
      return v;
   endfunction

   function automatic logic [W-1:0] ref_mul(input logic [M-1:0] av, input logic [M-1:0] bv,
                                            input int m);
      logic [W-1:0] p;
      p = '0;
      for (int i = 0; i < m; i++) begin
         if (bv[i]) p ^= (W'(av) << i);
      end
      return p;
   endfunction

   function automatic logic [W-1:0] ref_mod(input logic [W-1:0] p_in, input int m,
                                            input logic [M-1:0] poly);
      logic [W-1:0] p;
      logic [W-1:0] f;
      p = p_in;
      f = W'(poly) | (W'(1) << m);
      for (int i = 2 * m - 2; i >= m; i--) begin
         if (p[i]) p ^= (f << (i - m));
      end
      return p;
   endfunction

   function automatic logic [W-1:0] expected(input logic [1:0] s, input logic [M-1:0] av,
                                             input logic [M-1:0] bv, input logic rd);
      int           m;
      logic [M-1:0] poly;
      logic [W-1:0] p;
      m    = (s == 2'd2) ? 4 : M;
      poly = (s == 2'd2) ? POLY_SMALL : POLY_BIG;
      p    = ref_mul(av, bv, m);
      return rd ? ref_mod(p, m, poly) : p;
   endfunction

   function automatic int n_of(input logic [1:0] s);
      return (s == 2'd0) ? 18 : (s == 2'd1) ? 15 : 2;
   endfunction

   // One full operation with an immediate consumer; lat = -1 on timeout.
   task automatic run_op(input logic [1:0] s, input logic [M-1:0] av, input logic [M-1:0] bv,
                         input logic rd, output logic [W-1:0] yv, output int lat);
      int guard;
      sel   = s;
      guard = 0;
      @(negedge clk);
      while (!cur_in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      a_in = av; b_in = bv; reduce_in = rd; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a_in = rand_vec(); b_in = rand_vec(); reduce_in = ~rd;
      lat = 0;
      while (!cur_out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!cur_out_valid) lat = -1;
      yv = cur_y;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         checks++; if (cur_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, cur_in_ready); end
         checks++; if (cur_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, cur_out_valid); end
         checks++; if (cur_busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, cur_busy); end
         checks++; if (cur_y !== '0) begin errors++; $display("FAIL reset_y[%0d]: got %h expected 0", k, cur_y); end
         checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d expected 0", k, cur_state); end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [W-1:0] yv, ex;
      logic [M-1:0] bv;
      int lat;
      run_op(2'd0, M'(1), M'(1), 1'b0, yv, lat);
      checks++; if (yv !== W'(1)) begin errors++; $display("FAIL one_times_one: got %h expected 1", yv); end
      checks++; if (lat !== 18) begin errors++; $display("FAIL lat_unreduced: got %0d expected 18", lat); end
      run_op(2'd0, M'(1) << 282, M'(1) << 282, 1'b0, yv, lat);
      ex = W'(1) << 564;
      checks++; if (yv !== ex) begin errors++; $display("FAIL top_square_raw: got %h expected %h", yv, ex); end
      run_op(2'd0, M'(1) << 282, M'(1) << 282, 1'b1, yv, lat);
      ex = '0;
      ex[281] = 1'b1; ex[22] = 1'b1; ex[12] = 1'b1; ex[10] = 1'b1;
      ex[8] = 1'b1; ex[5] = 1'b1; ex[3] = 1'b1;
      checks++; if (yv !== ex) begin errors++; $display("FAIL top_square_red: got %h expected %h", yv, ex); end
      checks++; if (lat !== 19) begin errors++; $display("FAIL lat_reduced: got %0d expected 19", lat); end
      bv = rand_vec();
      run_op(2'd0, '0, bv, 1'b0, yv, lat);
      checks++; if (yv !== '0) begin errors++; $display("FAIL a_zero: got %h expected 0", yv); end
      run_op(2'd0, rand_vec(), '0, 1'b1, yv, lat);
      checks++; if (yv !== '0) begin errors++; $display("FAIL b_zero: got %h expected 0", yv); end
      run_op(2'd0, M'(1), bv, 1'b0, yv, lat);
      checks++; if (yv !== W'(bv)) begin errors++; $display("FAIL a_one: got %h expected %h", yv, W'(bv)); end
      run_op(2'd0, M'(1), bv, 1'b1, yv, lat);
      checks++; if (yv !== W'(bv)) begin errors++; $display("FAIL reduce_reduced: got %h expected %h", yv, W'(bv)); end
   endtask

   task automatic test_small_field();
      logic [W-1:0] yv;
      int lat;
      run_op(2'd2, M'(4'b1011), M'(4'b0110), 1'b0, yv, lat);
      checks++; if (yv !== W'(7'h3A)) begin errors++; $display("FAIL small_raw: got %h expected 3a", yv); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL small_raw_lat: got %0d expected 2", lat); end
      run_op(2'd2, M'(4'b1011), M'(4'b0110), 1'b1, yv, lat);
      checks++; if (yv !== W'(7'h0F)) begin errors++; $display("FAIL small_red: got %h expected 0f", yv); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL small_red_lat: got %0d expected 3", lat); end
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            for (int r = 0; r < 2; r++) begin
               run_op(2'd2, M'(i), M'(j), r[0], yv, lat);
               checks++;
               if (yv !== expected(2'd2, M'(i), M'(j), r[0])) begin
                  errors++;
                  $display("FAIL small_sweep a=%0d b=%0d r=%0d: got %h expected %h", i, j, r, yv[6:0],
                           expected(2'd2, M'(i), M'(j), r[0]));
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [M-1:0] av, bv;
      logic [W-1:0] y0, ex;
      int guard;
      sel = 2'd0;
      av = rand_vec(); bv = rand_vec();
      ex = expected(2'd0, av, bv, 1'b1);
      @(negedge clk);
      a_in = av; b_in = bv; reduce_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!cur_out_valid && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      y0 = cur_y;
      checks++; if (y0 !== ex) begin errors++; $display("FAIL bp_result: got %h expected %h", y0, ex); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0]; a_in = rand_vec(); b_in = rand_vec(); reduce_in = i[1];
         @(posedge clk); #1;
         checks++; if (cur_y !== y0) begin errors++; $display("FAIL bp_y_stable[%0d]: got %h expected %h", i, cur_y, y0); end
         checks++; if (cur_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, cur_in_ready); end
         checks++; if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, cur_out_valid); end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (cur_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", cur_out_valid); end
      checks++; if (cur_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", cur_in_ready); end
      checks++; if (cur_busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b expected 0", cur_busy); end
      checks++; if (cur_y !== y0) begin errors++; $display("FAIL bp_release_y: got %h expected %h", cur_y, y0); end
   endtask

   task automatic test_back_to_back();
      logic [M-1:0] av, bv;
      logic [W-1:0] ex;
      int accepts[$];
      int guard;
      for (int r = 0; r < 2; r++) begin
         sel = 2'd0;
         accepts.delete();
         av = rand_vec(); bv = rand_vec();
         ex = expected(2'd0, av, bv, r[0]);
         @(negedge clk);
         a_in = av; b_in = bv; reduce_in = r[0]; in_valid = 1'b1; out_ready = 1'b1;
         for (int c = 0; c < 3 * 21 + 2; c++) begin
            if (cur_in_ready) accepts.push_back(c);
            if (cur_out_valid) begin
               checks++;
               if (cur_y !== ex) begin errors++; $display("FAIL b2b_y r=%0d c=%0d: got %h expected %h", r, c, cur_y, ex); end
            end
            @(negedge clk);
         end
         in_valid = 1'b0;
         guard = 0;
         while (!cur_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         out_ready = 1'b0;
         checks++;
         if (accepts.size() < 3) begin
            errors++; $display("FAIL b2b_accepts r=%0d: got %0d expected >=3", r, accepts.size());
         end else begin
            checks++;
            if (accepts[1] - accepts[0] !== 20 + r) begin errors++; $display("FAIL b2b_period0 r=%0d: got %0d expected %0d", r, accepts[1] - accepts[0], 20 + r); end
            checks++;
            if (accepts[2] - accepts[1] !== 20 + r) begin errors++; $display("FAIL b2b_period1 r=%0d: got %0d expected %0d", r, accepts[2] - accepts[1], 20 + r); end
         end
      end
   endtask

   task automatic test_random();
      logic [M-1:0] av, bv;
      logic         rd;
      logic [W-1:0] yv, ex;
      int lat;
      for (int i = 0; i < 1100; i++) begin
         logic [1:0] s;
         s  = (i < 1000) ? 2'd1 : 2'd0;
         av = rand_vec(); bv = rand_vec();
         rd = 1'($urandom_range(0, 1));
         if (i == 0) av = '0;
         if (i == 1) bv = '0;
         if (i == 2) av = M'(1);
         if (i == 3) begin av = '1; bv = '1; end
         ex = expected(s, av, bv, rd);
         run_op(s, av, bv, rd, yv, lat);
         checks++;
         if (yv !== ex) begin errors++; $display("FAIL rand_y[%0d] s=%0d r=%0d: got %h expected %h", i, s, rd, yv, ex); end
         checks++;
         if (lat !== n_of(s) + int'(rd)) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", i, lat, n_of(s) + int'(rd)); end
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] yv;
      int lat, guard;
      sel = 2'd0;
      @(negedge clk);
      a_in = rand_vec(); b_in = rand_vec(); reduce_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (cur_in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 1", cur_in_ready); end
      checks++; if (cur_out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b expected 0", cur_out_valid); end
      checks++; if (cur_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", cur_busy); end
      checks++; if (cur_y !== '0) begin errors++; $display("FAIL mid_rst_y: got %h expected 0", cur_y); end
      checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d expected 0", cur_state); end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(2'd0, M'(3), M'(3), 1'b0, yv, lat);
      checks++; if (yv !== W'(5)) begin errors++; $display("FAIL post_rst_y: got %h expected 5", yv); end
      checks++; if (lat !== 18) begin errors++; $display("FAIL post_rst_lat: got %0d expected 18", lat); end
      @(negedge clk);
      a_in = M'(7); b_in = M'(9); reduce_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!cur_out_valid && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++; if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL done_before_rst: got %b expected 1", cur_out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (cur_out_valid !== 1'b0) begin errors++; $display("FAIL done_rst_out_valid: got %b expected 0", cur_out_valid); end
      checks++; if (cur_y !== '0) begin errors++; $display("FAIL done_rst_y: got %h expected 0", cur_y); end
      checks++; if (cur_in_ready !== 1'b1) begin errors++; $display("FAIL done_rst_in_ready: got %b expected 1", cur_in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(2'd0, M'(7), M'(9), 1'b1, yv, lat);
      checks++; if (yv !== W'(63)) begin errors++; $display("FAIL post_done_rst_y: got %h expected 3f", yv); end
   endtask

   initial begin
      sel = 2'd0; in_valid = 1'b0; a_in = '0; b_in = '0; reduce_in = 1'b0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_small_field();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
